// File: rtl/clb_cfg_pkg.sv
// Shared types and config-bit map for the CLB slice output stage.
package clb_cfg_pkg;

    typedef enum logic [1:0] {
        UNCONF   = 2'd0,
        SHIFT    = 2'd1,
        LOADINIT = 2'd2,
        RUN      = 2'd3
    } state_t;

    localparam int unsigned CFG_W_MIN     = 7;

    localparam int unsigned CFG_OUTSEL_LO = 0;
    localparam int unsigned CFG_OUTSEL_HI = 1;
    localparam int unsigned CFG_REGEN     = 2;
    localparam int unsigned CFG_CEUSED    = 3;
    localparam int unsigned CFG_SRVAL     = 4;
    localparam int unsigned CFG_INIT      = 5;
    localparam int unsigned CFG_SREN      = 6;

    localparam logic [1:0] OSEL_LUT = 2'b00;
    localparam logic [1:0] OSEL_SUM = 2'b01;
    localparam logic [1:0] OSEL_CY  = 2'b10;
    localparam logic [1:0] OSEL_BYP = 2'b11;

    function automatic logic out_mux(input logic [1:0] sel, input logic lut,
                                     input logic sum, input logic cy, input logic byp);
        logic r;
        case (sel)
            OSEL_LUT: r = lut;
            OSEL_SUM: r = sum;
            OSEL_CY:  r = cy;
            default:  r = byp;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/clb_cfg_shifter.sv
// Serial config shift register, burst bit counter and optional shadow register.
// Macro CLB_CFG_SHADOW_EN: active config is a shadow copy loaded on `load`.
module clb_cfg_shifter
    import clb_cfg_pkg::*;
#(
    parameter int unsigned CFG_W = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 shift_en,
    input  logic                 cfg_in,
    input  logic                 burst_start,
    input  logic                 load,
    output logic                 cfg_out,
    output logic                 count_ok,
    output logic                 init_new,
    output logic [CFG_W_MIN-1:0] cfg_active
);

    localparam int unsigned      CNT_W   = $clog2(CFG_W + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_OK  = CNT_W'(CFG_W);

    logic [CFG_W-1:0] sreg;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg  <= '0;
            count <= '0;
        end else if (shift_en) begin
            sreg <= {sreg[CFG_W-2:0], cfg_in};
            if (burst_start)
                count <= CNT_W'(1);
            else if (count != CNT_MAX)
                count <= count + CNT_W'(1);
        end
    end

    assign cfg_out  = sreg[CFG_W-1];
    assign count_ok = (count == CNT_OK);
    assign init_new = sreg[CFG_INIT];

`ifdef CLB_CFG_SHADOW_EN
    logic [CFG_W_MIN-1:0] shadow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            shadow <= '0;
        else if (load)
            shadow <= sreg[CFG_W_MIN-1:0];
    end

    assign cfg_active = shadow;
`else
    logic unused_load;
    assign unused_load = load;
    assign cfg_active  = sreg[CFG_W_MIN-1:0];
`endif

    // Bits above the mapped field are reserved: they only pass through to cfg_out.
    if (CFG_W > CFG_W_MIN + 1) begin : g_rsvd
        logic unused_rsvd;
        assign unused_rsvd = ^sreg[CFG_W-2:CFG_W_MIN];
    end

endmodule

// File: rtl/clb_output_register.sv
// Slice output stage: config FSM, output select mux and storage flip-flop.
// Macro CLB_CFG_SHADOW_EN: shadowed config, bad burst keeps the previous config.
module clb_output_register
    import clb_cfg_pkg::*;
#(
    parameter int unsigned CFG_W = 7
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cfg_shift_en,
    input  logic cfg_in,
    output logic cfg_out,
    input  logic lut_in,
    input  logic sum_in,
    input  logic cy_in,
    input  logic byp_in,
    input  logic ce,
    input  logic sr,
    output logic slice_out,
    output logic ff_q,
    output logic cfg_valid,
    output logic cfg_err
);

    state_t               state, state_nxt, err_target;
    logic                 err_nxt, ff_nxt, d;
    logic                 count_ok, init_new;
    logic [CFG_W_MIN-1:0] cfg_active;
    logic                 burst_start, load;
    logic                 unused_init;

    assign burst_start = cfg_shift_en && (state != SHIFT);
    assign load        = (state == LOADINIT);
    assign unused_init = cfg_active[CFG_INIT];

    clb_cfg_shifter #(.CFG_W(CFG_W)) u_shifter (
        .clk         (clk),
        .reset_n     (reset_n),
        .shift_en    (cfg_shift_en),
        .cfg_in      (cfg_in),
        .burst_start (burst_start),
        .load        (load),
        .cfg_out     (cfg_out),
        .count_ok    (count_ok),
        .init_new    (init_new),
        .cfg_active  (cfg_active)
    );

`ifdef CLB_CFG_SHADOW_EN
    logic have_cfg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            have_cfg <= 1'b0;
        else if (state == LOADINIT)
            have_cfg <= 1'b1;
    end

    assign err_target = have_cfg ? RUN : UNCONF;
`else
    assign err_target = UNCONF;
`endif

    always_comb begin
        state_nxt = state;
        err_nxt   = cfg_err;
        ff_nxt    = ff_q;
        slice_out = 1'b0;
        cfg_valid = 1'b0;
        d = out_mux(cfg_active[CFG_OUTSEL_HI:CFG_OUTSEL_LO], lut_in, sum_in, cy_in, byp_in);
        case (state)
            UNCONF: begin
                if (cfg_shift_en) begin
                    state_nxt = SHIFT;
                    err_nxt   = 1'b0;
                end
            end
            SHIFT: begin
                if (!cfg_shift_en) begin
                    if (count_ok) begin
                        state_nxt = LOADINIT;
                    end else begin
                        state_nxt = err_target;
                        err_nxt   = 1'b1;
                    end
                end
            end
            LOADINIT: begin
                // INIT comes from the freshly shifted bits, even if a new burst starts now.
                ff_nxt = init_new;
                if (cfg_shift_en) begin
                    state_nxt = SHIFT;
                    err_nxt   = 1'b0;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                cfg_valid = 1'b1;
                slice_out = cfg_active[CFG_REGEN] ? ff_q : d;
                if (cfg_active[CFG_SREN] && sr)
                    ff_nxt = cfg_active[CFG_SRVAL];
                else if (!cfg_active[CFG_CEUSED] || ce)
                    ff_nxt = d;
                if (cfg_shift_en) begin
                    state_nxt = SHIFT;
                    err_nxt   = 1'b0;
                end
            end
            default: state_nxt = UNCONF;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= UNCONF;
            cfg_err <= 1'b0;
            ff_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cfg_err <= err_nxt;
            ff_q    <= ff_nxt;
        end
    end

endmodule

// File: tb/tb_clb_output_register.sv
// Scoreboard bench for clb_output_register: two daisy-chained slices, directed vectors.
module tb_clb_output_register;

    localparam logic [4:0] M_ALL  = 5'b11111;
    localparam logic [4:0] M_NOCO = 5'b11110;
    localparam logic [4:0] M_CO   = 5'b00001;
    localparam logic [4:0] M_ERR  = 5'b00010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, en0, en1, cfg_in;
    logic lut_in, sum_in, cy_in, byp_in, ce, sr;
    logic so0, q0, v0, e0, co0;
    logic so1, q1, v1, e1, co1;
    logic [4:0] act0, act1;

    // Output vector order: {slice_out, ff_q, cfg_valid, cfg_err, cfg_out}
    assign act0 = {so0, q0, v0, e0, co0};
    assign act1 = {so1, q1, v1, e1, co1};

    clb_output_register #(.CFG_W(7)) u0 (
        .clk(clk), .reset_n(reset_n), .cfg_shift_en(en0), .cfg_in(cfg_in), .cfg_out(co0),
        .lut_in(lut_in), .sum_in(sum_in), .cy_in(cy_in), .byp_in(byp_in), .ce(ce), .sr(sr),
        .slice_out(so0), .ff_q(q0), .cfg_valid(v0), .cfg_err(e0)
    );

    clb_output_register #(.CFG_W(7)) u1 (
        .clk(clk), .reset_n(reset_n), .cfg_shift_en(en1), .cfg_in(co0), .cfg_out(co1),
        .lut_in(lut_in), .sum_in(sum_in), .cy_in(cy_in), .byp_in(byp_in), .ce(ce), .sr(sr),
        .slice_out(so1), .ff_q(q1), .cfg_valid(v1), .cfg_err(e1)
    );

    typedef struct {
        string      name;
        int         cyc;
        int         which;
        logic [4:0] mask;
        logic [4:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_o(input string name, input int which, input logic [4:0] mask,
                            input logic [4:0] e);
        exp_t t;
        t.name = name; t.cyc = cyc; t.which = which; t.mask = mask; t.exp = e;
        sb.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends v[n-1:0] MSB first into slice 0, optionally checking the first SHIFT cycle.
    task automatic shift_bits(input logic [6:0] v, input int n, input logic chk_mid,
                              input logic q_hold, input string name);
        for (int i = n - 1; i >= 0; i--) begin
            cfg_in = v[i];
            en0    = 1'b1;
            step();
            if (chk_mid && i == n - 1)
                expect_o(name, 0, M_NOCO, {1'b0, q_hold, 3'b000});
        end
        en0    = 1'b0;
        cfg_in = 1'b0;
    endtask

    // Monitor: compares every queued expectation in the cycle it belongs to.
    initial begin
        exp_t       t;
        logic [4:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                t   = sb.pop_front();
                act = (t.which == 0) ? act0 : act1;
                checks++;
                if (t.cyc != cyc || (act & t.mask) !== (t.exp & t.mask)) begin
                    failures++;
                    $display("FAIL %s (u%0d): got %b expected %b mask %b", t.name, t.which,
                             act & t.mask, t.exp & t.mask, t.mask);
                end
            end
            if (done || cyc > 2000) begin
                if (!done) begin
                    failures++;
                    $display("FAIL watchdog: got cycle %0d expected stimulus done", cyc);
                end
                while (sb.size() > 0) begin
                    t = sb.pop_front();
                    failures++;
                    $display("FAIL %s: got no sample expected %b", t.name, t.exp);
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin
        logic [20:0] stream;
        reset_n = 1'b1; en0 = 1'b0; en1 = 1'b0; cfg_in = 1'b0;
        lut_in = 1'b0; sum_in = 1'b0; cy_in = 1'b0; byp_in = 1'b0; ce = 1'b0; sr = 1'b0;
        #2 reset_n = 1'b0;
        step();
        expect_o("reset", 0, M_ALL, 5'b00000);
        expect_o("reset", 1, M_ALL, 5'b00000);
        step();
        reset_n = 1'b1;

        // 1: idle after reset
        repeat (5) step();
        expect_o("t1_idle", 0, M_ALL, 5'b00000);

        // 2: sum, registered, SR_EN, INIT=1
        shift_bits(7'b1100101, 7, 1'b1, 1'b0, "t2_mid");
        expect_o("t2_shifted", 0, M_ALL, 5'b00001);
        step();
        expect_o("t2_loadinit", 0, M_ALL, 5'b00001);
        lut_in = 1'b1; cy_in = 1'b0; sum_in = 1'b0;
        step();
        expect_o("t2_init", 0, M_NOCO, 5'b11100);
        step();
        sum_in = 1'b1;
        expect_o("t2_d0_latency", 0, M_NOCO, 5'b00100);
        step();
        sr = 1'b1;
        expect_o("t2_d1", 0, M_NOCO, 5'b11100);
        step();
        sr = 1'b0;
        expect_o("t2_sr", 0, M_NOCO, 5'b00100);
        step();
        expect_o("t2_sr_release", 0, M_NOCO, 5'b11100);

        // 3: lut, combinational, CE_USED
        ce = 1'b0;
        shift_bits(7'b0001000, 7, 1'b1, 1'b1, "t3_mid_hold");
        step();
        step();
        expect_o("t3_run", 0, M_NOCO, 5'b10100);
        step();
        lut_in = 1'b0;
        expect_o("t3_comb0", 0, M_NOCO, 5'b00100);
        step();
        lut_in = 1'b1;
        expect_o("t3_comb1", 0, M_NOCO, 5'b10100);
        step();
        ce = 1'b1;
        expect_o("t3_ce_hold", 0, M_NOCO, 5'b10100);
        step();
        expect_o("t3_ce_load", 0, M_NOCO, 5'b11100);

        // 4: short burst, then a good burst (cy, registered, INIT=0)
        shift_bits(7'b0111111, 6, 1'b0, 1'b0, "t4_unused");
        step();
`ifdef CLB_CFG_SHADOW_EN
        expect_o("t4_badcount", 0, M_NOCO, 5'b11110);
`else
        expect_o("t4_badcount", 0, M_NOCO, 5'b01010);
`endif
        shift_bits(7'b0000110, 7, 1'b1, 1'b1, "t4_err_clear");
        step();
        step();
        cy_in = 1'b0;
        expect_o("t4_recover", 0, M_NOCO, 5'b00100);
        cy_in = 1'b1;
        step();
        expect_o("t4_cy", 0, M_NOCO, 5'b11100);
        cy_in = 1'b0;

        // 5: chained stream A (for u1), B (ends in u0), then zeros to flush B out
        stream = {7'b0100011, 7'b1011001, 7'b0000000};
        for (int k = 1; k <= 21; k++) begin
            cfg_in = stream[21-k];
            en0    = 1'b1;
            en1    = (k >= 8 && k <= 14);
            if (k == 17) byp_in = 1'b1;
            if (k == 18) byp_in = 1'b0;
            if (k >= 8)
                expect_o($sformatf("t5_chain_%0d", k), 0, M_CO, {4'b0000, stream[28-k]});
            if (k == 17) expect_o("t5_u1_init", 1, M_NOCO, 5'b11100);
            if (k == 18) expect_o("t5_u1_comb", 1, M_NOCO, 5'b01100);
            if (k == 19) expect_o("t5_u1_ff", 1, M_NOCO, 5'b00100);
            step();
        end
        en0 = 1'b0; en1 = 1'b0; cfg_in = 1'b0;
        step();
        expect_o("t5_u0_longburst_err", 0, M_ERR, 5'b00010);

        // 6: reset during the 4th shift bit, then a full re-shift
        for (int j = 1; j <= 3; j++) begin
            cfg_in = 1'b1;
            en0    = 1'b1;
            step();
        end
        cfg_in  = 1'b0;
        reset_n = 1'b0;
        expect_o("t6_reset_u0", 0, M_ALL, 5'b00000);
        expect_o("t6_reset_u1", 1, M_ALL, 5'b00000);
        step();
        reset_n = 1'b1;
        en0     = 1'b0;
        step();
        shift_bits(7'b1100101, 7, 1'b1, 1'b0, "t6_mid");
        step();
        step();
        expect_o("t6_reshift", 0, M_NOCO, 5'b11100);
        step();
        done = 1'b1;
    end

endmodule
